fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, 2, fetch-buffer entries, allowed values 2 or 4.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  decode-register hold; the head instruction is not consumed.
REQ-006 jb  in  1  jump/branch redirect from execute.
REQ-007 jb_target  in  32  redirect address.
REQ-008 imem_req_valid  out  1  instruction-memory request valid.
REQ-009 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_req_addr  out  32  word-aligned fetch address.
REQ-011 imem_resp_valid  in  1  read data valid; responses return in request order, latency of 1 or more cycles.
REQ-012 imem_resp_data  in  32  instruction word.
REQ-013 pc_out  out  32  PC of the head instruction, or 0 when empty.
REQ-014 inst_out  out  32  head instruction, or NOP 32'h0000_0013 when empty.
REQ-015 inst_valid  out  1  the head of the buffer is a real instruction.

Function
REQ-016 The unit SHALL hold fetch_pc, an in-flight request counter, a drop counter and a FIFO of {pc, inst} pairs.
REQ-017 imem_req_valid SHALL be 1 when (in_flight + fifo_count) < FIFO_DEPTH and jb=0; imem_req_addr SHALL equal fetch_pc.
REQ-018 On request accept (valid and ready), fetch_pc SHALL advance by 4, wrap modulo 2^32 (32'hFFFF_FFFC -> 0), and in_flight SHALL increment.
REQ-019 On imem_resp_valid, in_flight SHALL decrement.
- If drop_cnt > 0: the response is discarded and drop_cnt decrements.
- Otherwise {pc of the oldest request, data} is pushed into the FIFO.
REQ-020 Outputs SHALL be combinational from the FIFO head: zero added latency from buffer to output, and a minimum of 1 cycle from response to output.
REQ-021 Pop SHALL occur when inst_valid=1, stall=0 and jb=0; stall=1 SHALL hold the head and all outputs unchanged.
REQ-022 When jb=1:
- fetch_pc <= {jb_target[31:2], 2'b00}.
- The FIFO is emptied.
- drop_cnt <= in_flight after this cycle's response decrement.
- No request is issued and no pop occurs.
REQ-023 jb SHALL take priority over stall; simultaneous jb and stall SHALL flush the unit.
REQ-024 Simultaneous push and pop with a full FIFO SHALL be legal and preserve the count; the bound in REQ-017 guarantees that a push never overflows the FIFO.
REQ-025 A response arriving while drop_cnt > 0 and jb=1 in the same cycle SHALL be dropped, and the reloaded drop_cnt SHALL exclude it.

Reset
REQ-026 On rst=1 at a clock edge, the unit SHALL set:
- fetch_pc = RESET_PC.
- in_flight = 0, drop_cnt = 0, FIFO empty.
- pc_out = 0, inst_out = NOP, inst_valid = 0, imem_req_valid = 0 for that cycle.
REQ-027 Reset asserted mid-operation SHALL abandon outstanding requests without counting them; the memory is reset by the same rst.

Configuration
REQ-028 When FETCH_PERF_CNT_EN is defined, the unit SHALL add:
- Output port fetch_bubble_cnt[31:0], reset to 0.
- The counter increments each cycle with inst_valid=0, stall=0 and rst=0.
- The counter saturates at 32'hFFFF_FFFF.
REQ-029 When FETCH_PERF_CNT_EN is undefined, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package cpu_pkg SHALL define XLEN=32 and NOP_INST=32'h0000_0013, and decode-side NOP insertion SHALL use the same constant.
REQ-031 The FIFO SHALL be a sub-module fetch_fifo with push, pop, flush, full, empty and count, using pointer wrap modulo FIFO_DEPTH.

Verification
REQ-032 Reset, then ready=1 and resp latency 1: imem_req_addr shows 0x0, 0x4, 0x8; inst_valid rises 2 cycles after reset release with pc_out=0x0.
REQ-033 stall held 3 cycles with the FIFO full: imem_req_valid=0, and pc_out/inst_out stay constant; on release, consecutive PCs appear with no gap.
REQ-034 jb=1, jb_target=0x100 with 2 requests in flight: both stale responses are dropped, and the next inst_valid carries pc_out=0x100.
REQ-035 jb and stall asserted together: flush occurs, and the next valid pc_out is the target.
REQ-036 RESET_PC=0xFFFF_FFF8: request addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; jb_target=0x103 yields a fetch at 0x100.
REQ-037 FETCH_PERF_CNT_EN defined, imem_req_ready=0 for 10 cycles after reset: fetch_bubble_cnt=10.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the front end and decode.
//   XLEN          - datapath width.
//   NOP_INST      - canonical NOP (addi x0, x0, 0). The fetch unit emits it on
//                   an empty buffer and decode uses it when inserting bubbles.
//   fetch_entry_t - one fetch-buffer record: {pc, inst}.
//   pc_plus4      - sequential next PC, wrapping modulo 2^XLEN.
//   word_align    - clears the two byte-offset bits of an address.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch_entry_t records.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the buffer)
//   push, din  - write din at the tail; ignored when full unless popping
//   pop        - drop the head; ignored when empty
//   flush      - empty the buffer this cycle; wins over push and pop
//   head       - current head record (valid only when !empty)
//   full, empty, count - occupancy status
// Read and write pointers wrap modulo DEPTH.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with an in-order memory interface
// and a small decoupling buffer.
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (2 or 4).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   stall                       - decode holds the head instruction
//   jb, jb_target               - redirect from execute (wins over stall)
//   imem_req_valid/ready/addr   - request channel (valid/ready handshake)
//   imem_resp_valid/data        - in-order response channel, latency >= 1
//   pc_out, inst_out, inst_valid- head of the buffer (0 / NOP when empty)
//   fetch_bubble_cnt            - only with FETCH_PERF_CNT_EN defined:
//                                 saturating count of unstalled empty cycles
// Handshake: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both 1; valid never depends on ready. The head is
// consumed on a cycle where inst_valid=1, stall=0 and jb=0.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_bubble_cnt,
`endif
    output logic        inst_valid
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;     // PC that the next kept response belongs to
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_din;

    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [CW-1:0] in_flight_dec;

    // Outstanding requests plus buffered entries never exceed the buffer, so a
    // response always has room even if decode stalls indefinitely.
    assign occupancy      = {1'b0, in_flight} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !jb && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored so the counter cannot wrap.
    assign resp_take      = imem_resp_valid && (in_flight != '0);
    assign resp_drop      = resp_take && (drop_cnt != '0);
    assign in_flight_dec  = resp_take ? in_flight - 1'b1 : in_flight;

    assign push           = resp_take && !resp_drop && !jb;
    assign pop            = inst_valid && !stall && !jb;
    assign fifo_din       = '{pc: resp_pc, inst: imem_resp_data};

    assign inst_valid     = !rst && !fifo_empty;
    assign pc_out         = inst_valid ? fifo_head.pc   : 32'h0;
    assign inst_out       = inst_valid ? fifo_head.inst : NOP_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else if (jb) begin
            // Every request still outstanding after this cycle is stale.
            fetch_pc  <= word_align(jb_target);
            resp_pc   <= word_align(jb_target);
            in_flight <= in_flight_dec;
            drop_cnt  <= in_flight_dec;
        end else begin
            if (req_fire) begin
                fetch_pc <= pc_plus4(fetch_pc);
            end
            in_flight <= req_fire ? in_flight_dec + 1'b1 : in_flight_dec;
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (push) begin
                resp_pc <= pc_plus4(resp_pc);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .flush (jb),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_bubble_cnt <= '0;
        end else if (!inst_valid && !stall && (fetch_bubble_cnt != 32'hFFFF_FFFF)) begin
            fetch_bubble_cnt <= fetch_bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A behavioural instruction
// memory with configurable latency answers requests in order; a table of
// per-cycle vectors covers streaming, stall and ready backpressure, and
// hand-written sequences cover redirects and the wrap-around reset PC.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jb;
    logic [31:0] jb_target;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_data;

    logic        rv1, iv1, rv2, iv2;
    logic [31:0] addr1, pc1, inst1, addr2, pc2, inst2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bub1, bub2;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .jb(jb), .jb_target(jb_target),
        .imem_req_valid(rv1), .imem_req_ready(ready), .imem_req_addr(addr1),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .pc_out(pc1), .inst_out(inst1),
`ifdef FETCH_PERF_CNT_EN
        .fetch_bubble_cnt(bub1),
`endif
        .inst_valid(iv1)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .jb(jb), .jb_target(jb_target),
        .imem_req_valid(rv2), .imem_req_ready(ready), .imem_req_addr(addr2),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .pc_out(pc2), .inst_out(inst2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_bubble_cnt(bub2),
`endif
        .inst_valid(iv2)
    );

    // ---------------- memory model ----------------
    logic        sel;          // 0: memory serves dut1, 1: dut2
    int          lat;
    int          cyc;
    logic [31:0] mq_addr[$];
    int          mq_time[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic drive_resp();
        if (!rst && mq_addr.size() > 0 && mq_time[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(mq_addr[0]);
        end else begin
            resp_valid = 1'b0;
            resp_data  = 32'h0;
        end
    endtask

    task automatic cycle();
        logic        acc;
        logic [31:0] acc_addr;
        logic        had_resp;
        acc      = sel ? (rv2 && ready) : (rv1 && ready);
        acc_addr = sel ? addr2 : addr1;
        had_resp = resp_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mq_addr.delete();
            mq_time.delete();
        end else begin
            if (had_resp) begin
                void'(mq_addr.pop_front());
                void'(mq_time.pop_front());
            end
            if (acc) begin
                mq_addr.push_back(acc_addr);
                mq_time.push_back(cyc + lat - 1);
            end
        end
        drive_resp();
    endtask

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; jb = 1'b0; jb_target = 32'h0;
        resp_valid = 1'b0; resp_data = 32'h0;
        cycle();
        cycle();
        rst = 1'b0;
        drive_resp();
        #1;
    endtask

    task automatic wait_valid(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sel ? iv2 : iv1) begin
                ok = 1'b1;
                break;
            end
            cycle();
            #1;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic setv(input int i, input logic s, input logic r, input logic erv,
                        input logic [31:0] ea, input logic eiv, input logic [31:0] epc);
        vecs[i] = '{stall: s, ready: r, exp_rv: erv, exp_addr: ea, exp_iv: eiv, exp_pc: epc};
    endtask

    logic ok;

    initial begin
        // stall ready | req_valid addr | inst_valid pc   (latency 1)
        setv( 0, 0, 1, 1, 32'h00, 0, 32'h00);
        setv( 1, 0, 1, 1, 32'h04, 0, 32'h00);
        setv( 2, 0, 1, 0, 32'h08, 1, 32'h00);
        setv( 3, 0, 1, 1, 32'h08, 1, 32'h04);
        setv( 4, 0, 1, 1, 32'h0C, 0, 32'h00);
        setv( 5, 0, 1, 0, 32'h10, 1, 32'h08);
        setv( 6, 0, 1, 1, 32'h10, 1, 32'h0C);
        setv( 7, 0, 1, 1, 32'h14, 0, 32'h00);
        setv( 8, 1, 1, 0, 32'h18, 1, 32'h10);
        setv( 9, 1, 1, 0, 32'h18, 1, 32'h10);
        setv(10, 1, 1, 0, 32'h18, 1, 32'h10);
        setv(11, 1, 1, 0, 32'h18, 1, 32'h10);
        setv(12, 0, 1, 0, 32'h18, 1, 32'h10);
        setv(13, 0, 1, 1, 32'h18, 1, 32'h14);
        setv(14, 0, 1, 1, 32'h1C, 0, 32'h00);
        setv(15, 0, 1, 0, 32'h20, 1, 32'h18);
        setv(16, 0, 0, 1, 32'h20, 1, 32'h1C);
        setv(17, 0, 0, 1, 32'h20, 0, 32'h00);
        setv(18, 0, 1, 1, 32'h20, 0, 32'h00);
        setv(19, 0, 1, 1, 32'h24, 0, 32'h00);
        setv(20, 0, 1, 0, 32'h28, 1, 32'h20);

        sel = 1'b0; lat = 1; cyc = 0; ready = 1'b1;
        mq_addr.delete(); mq_time.delete();

        // Reset: outputs quiet while rst is high.
        rst = 1'b1; stall = 1'b0; jb = 1'b0; jb_target = 32'h0;
        resp_valid = 1'b0; resp_data = 32'h0;
        cycle();
        #1;
        chk("rst_req_valid", {31'b0, rv1}, 32'd0);
        chk("rst_inst_valid", {31'b0, iv1}, 32'd0);
        chk("rst_pc_out", pc1, 32'h0);
        chk("rst_inst_out", inst1, NOP_INST);
        rst = 1'b0;
        drive_resp();
        #1;

        // Table: streaming, stall with full buffer, ready backpressure.
        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;
            ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_req_valid", i), {31'b0, rv1}, {31'b0, vecs[i].exp_rv});
            chk($sformatf("v%0d_req_addr", i), addr1, vecs[i].exp_addr);
            chk($sformatf("v%0d_inst_valid", i), {31'b0, iv1}, {31'b0, vecs[i].exp_iv});
            chk($sformatf("v%0d_pc_out", i), pc1, vecs[i].exp_pc);
            chk($sformatf("v%0d_inst_out", i), inst1,
                vecs[i].exp_iv ? mem_word(vecs[i].exp_pc) : NOP_INST);
            cycle();
        end
        stall = 1'b0; ready = 1'b1;

        // Redirect with two requests in flight (latency 3).
        lat = 3;
        do_reset();
        cycle();            // accept 0x0
        cycle();            // accept 0x4
        #1;
        chk("jb_req_valid_full", {31'b0, rv1}, 32'd0);
        jb = 1'b1; jb_target = 32'h100;
        #1;
        chk("jb_req_valid_blocked", {31'b0, rv1}, 32'd0);
        cycle();
        jb = 1'b0;
        #1;
        chk("jb_addr_after", addr1, 32'h100);
        wait_valid(20, ok);
        chk("jb_valid_seen", {31'b0, ok}, 32'd1);
        chk("jb_first_pc", pc1, 32'h100);
        chk("jb_first_inst", inst1, mem_word(32'h100));
        cycle();
        wait_valid(10, ok);
        chk("jb_second_pc", pc1, 32'h104);

        // Redirect and stall in the same cycle (latency 1).
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        #1;
        stall = 1'b1; jb = 1'b1; jb_target = 32'h200;
        #1;
        chk("jbst_req_valid", {31'b0, rv1}, 32'd0);
        cycle();
        stall = 1'b0; jb = 1'b0;
        #1;
        chk("jbst_flushed", {31'b0, iv1}, 32'd0);
        chk("jbst_addr", addr1, 32'h200);
        wait_valid(20, ok);
        chk("jbst_valid_seen", {31'b0, ok}, 32'd1);
        chk("jbst_pc", pc1, 32'h200);
        chk("jbst_inst", inst1, mem_word(32'h200));

        // Reset PC near the top of the address space, with unaligned redirect.
        sel = 1'b1;
        do_reset();
        chk("wrap_a0_valid", {31'b0, rv2}, 32'd1);
        chk("wrap_a0", addr2, 32'hFFFF_FFF8);
        cycle();
        chk("wrap_a1", addr2, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_a2_held", {31'b0, rv2}, 32'd0);
        cycle();
        chk("wrap_a3_valid", {31'b0, rv2}, 32'd1);
        chk("wrap_a3", addr2, 32'h0000_0000);
        chk("wrap_head_pc", pc2, 32'hFFFF_FFFC);
        jb = 1'b1; jb_target = 32'h103;
        #1;
        cycle();
        jb = 1'b0;
        #1;
        chk("wrap_jb_addr", addr2, 32'h100);
        chk("wrap_jb_req_valid", {31'b0, rv2}, 32'd1);
        wait_valid(20, ok);
        chk("wrap_jb_valid_seen", {31'b0, ok}, 32'd1);
        chk("wrap_jb_pc", pc2, 32'h100);
        sel = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        // Bubble counter: memory never ready for 10 cycles after reset.
        ready = 1'b0;
        do_reset();
        chk("bub_after_reset", bub1, 32'd0);
        for (int i = 0; i < 10; i++) cycle();
        #1;
        chk("bub_10", bub1, 32'd10);
        stall = 1'b1;
        cycle();
        #1;
        chk("bub_stall_hold", bub1, 32'd10);
        stall = 1'b0;
        ready = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
